neander_io_port: RTL

Memory-mapped-free I/O responder for the NEANDER-X CPU: it sits on the CPU side of the `io_out`/`io_write`/`io_in`/`io_status` interface and services the CPU's OUT and IN instructions. Bytes written by OUT are buffered in a small TX FIFO and drained to an external consumer over a valid/ready handshake. IN data comes from a 2-flop-synchronised external input port. `io_status` reports FIFO state, so firmware can poll before writing.

---
 rtl/neander_io_port_if.sv | 31 +++
 rtl/neander_io_port.sv | 86 ++++++++
 2 files changed

// File: rtl/neander_io_port_if.sv
// neander_io_port_if
//   Groups the CPU-side I/O bus (io_out/io_write/io_in/io_status), the
//   external input pins and the TX drain handshake of neander_io_port.
//
//   Handshake: a byte moves from out_data to the consumer on every rising
//   clock edge where out_valid and out_ready are both 1. out_valid never
//   depends on out_ready. out_data is held stable while out_valid=1 and
//   out_ready=0.
//
//   modport slave  : the I/O port itself.
//   modport master : the CPU plus external pins/consumer environment.
interface neander_io_port_if;
  logic [7:0] io_out;
  logic       io_write;
  logic [7:0] io_in;
  logic [7:0] io_status;
  logic [7:0] pins_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  io_out, io_write, pins_in, out_ready,
    output io_in, io_status, out_data, out_valid
  );

  modport master (
    output io_out, io_write, pins_in, out_ready,
    input  io_in, io_status, out_data, out_valid
  );
endinterface

// File: rtl/neander_io_port.sv
// neander_io_port
//   I/O responder for the NEANDER-X CPU. OUT bytes are pushed into a small
//   TX FIFO and drained over a valid/ready handshake. IN data comes from a
//   2-flop synchroniser on the external pins. io_status exposes FIFO state.
//
// Ports
//   clk    : system clock, rising edge.
//   reset  : synchronous, active-high.
//   bus    : neander_io_port_if.slave
//            io_out/io_write  CPU OUT byte and one-cycle strobe
//            io_in            synchronised pins_in (2-cycle latency)
//            io_status        {0, count[2:0], 0, ovf, tx_full, tx_empty}
//            pins_in          asynchronous input pins
//            out_data/out_valid/out_ready  TX drain handshake
//
// Parameter DEPTH: 2 or 4 entries (count stays within 3 bits).
module neander_io_port #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  neander_io_port_if.slave  bus
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    sync1_q, sync2_q;

  logic empty, full, push, pop;

  assign empty = (count_q == 3'd0);
  assign full  = (count_q == 3'(DEPTH));
  assign pop   = !empty && bus.out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push  = bus.io_write && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    // Write refused: byte dropped, sticky flag until reset.
    if (bus.io_write && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sync1_q  <= bus.pins_in;
      sync2_q  <= sync1_q;
    end
  end

  // Storage has no reset; entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= bus.io_out;
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = !empty;
  assign bus.io_in     = sync2_q;
  assign bus.io_status = {1'b0, count_q, 1'b0, ovf_q, full, empty};

endmodule
